load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM state type and decode helpers for the load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_RESP
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return MASK_B;
      F3_H, F3_HU: return MASK_H;
      F3_W:        return MASK_W;
      default:     return 4'b0000;
    endcase
  endfunction

  // Unsigned widths only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: store shift/byte enables and load shift/extension.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [3:0]  o_be_lo,
  output logic [3:0]  o_be_hi,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [31:0] o_load_data
);

  logic [4:0]  w_sh;
  logic [7:0]  w_be;
  logic [63:0] w_wd;
  logic [63:0] w_rd;

  // Treat the two words as one 64-bit window so crossing accesses need no special case.
  assign w_sh = {i_offset, 3'b000};
  assign w_be = {4'b0000, size_mask(i_funct3)} << i_offset;
  assign w_wd = {32'h0, i_wdata} << w_sh;
  assign w_rd = {i_rdata_hi, i_rdata_lo} >> w_sh;

  assign o_be_lo    = w_be[3:0];
  assign o_be_hi    = w_be[7:4];
  assign o_wdata_lo = w_wd[31:0];
  assign o_wdata_hi = w_wd[63:32];

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_rd[7]}}, w_rd[7:0]};
      F3_H:    o_load_data = {{16{w_rd[15]}}, w_rd[15:0]};
      F3_W:    o_load_data = w_rd[31:0];
      F3_BU:   o_load_data = {24'h0, w_rd[7:0]};
      F3_HU:   o_load_data = {16'h0, w_rd[15:0]};
      default: o_load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; splits word-crossing accesses into two bus beats.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state, w_next;
  logic        r_we, r_resp_valid, r_resp_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_lo, r_hi, r_resp_rdata;

  logic        w_accept, w_reject, w_split;
  logic [3:0]  w_be_lo, w_be_hi;
  logic [31:0] w_wd_lo, w_wd_hi, w_load, w_lo_in, w_hi_in, w_word_addr;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_reject  = !f3_legal(req_funct3, req_we) ||
                     ((MISALIGN_SPLIT == 0) && misaligned(req_funct3, req_addr[1:0]));
  assign w_split   = |w_be_hi;

  // Bypass the returning word so the response can be registered on the same edge it arrives.
  assign w_lo_in = (r_state == S_WAIT1) ? mem_rdata : r_lo;
  assign w_hi_in = (r_state == S_WAIT2) ? mem_rdata : r_hi;

  lsu_lane_align u_align (
    .i_funct3    (r_f3),
    .i_offset    (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .i_rdata_lo  (w_lo_in),
    .i_rdata_hi  (w_hi_in),
    .o_be_lo     (w_be_lo),
    .o_be_hi     (w_be_hi),
    .o_wdata_lo  (w_wd_lo),
    .o_wdata_hi  (w_wd_hi),
    .o_load_data (w_load)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)   w_next = w_reject ? S_RESP : S_ISSUE1;
      S_ISSUE1: if (mem_gnt)    w_next = S_WAIT1;
      S_WAIT1:  if (mem_rvalid) w_next = w_split ? S_ISSUE2 : S_RESP;
      S_ISSUE2: if (mem_gnt)    w_next = S_WAIT2;
      S_WAIT2:  if (mem_rvalid) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_word_addr = {r_addr[31:2], 2'b00};

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == S_ISSUE1) begin
      mem_req   = 1'b1;
      mem_we    = r_we;
      mem_be    = w_be_lo;
      mem_addr  = w_word_addr;
      mem_wdata = w_wd_lo;
    end else if (r_state == S_ISSUE2) begin
      mem_req   = 1'b1;
      mem_we    = r_we;
      mem_be    = w_be_hi;
      mem_addr  = w_word_addr + 32'd4;
      mem_wdata = w_wd_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == S_WAIT1) && mem_rvalid) r_lo <= mem_rdata;
      if ((r_state == S_WAIT2) && mem_rvalid) r_hi <= mem_rdata;
      r_resp_valid <= (w_next == S_RESP);
      r_resp_err   <= (r_state == S_IDLE) && (w_next == S_RESP);
      r_resp_rdata <= ((w_next == S_RESP) && (r_state != S_IDLE) && !r_we) ? w_load : '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: split/no-split units driven side by side with a scripted memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt = 0, mem_we, mem_rvalid = 0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;

  logic        b_req_valid = 0, b_req_ready, b_req_we = 0;
  logic [2:0]  b_req_funct3 = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic        b_mem_req, b_mem_we;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_addr, b_mem_wdata;

  int n_assert = 0;
  int n_fail = 0;

  load_store_unit #(.MISALIGN_SPLIT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.MISALIGN_SPLIT(0)) dut_nosplit (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_req(b_mem_req), .mem_gnt(1'b0), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rvalid(1'b0), .mem_rdata(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, req_ready, 1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // One memory beat: check the request, optionally stall the grant, then answer.
  task automatic serve(input logic [31:0] a, input logic [3:0] be, input logic we,
                       input logic [31:0] wd, input logic [31:0] rd, input int stall,
                       input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk({tag, " mem_req"}, mem_req, 1);
    chk({tag, " addr"}, mem_addr, a);
    chk({tag, " be"}, mem_be, be);
    chk({tag, " we"}, mem_we, we);
    if (we) chk({tag, " wdata"}, mem_wdata & lane_mask(be), wd);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " hold req"}, mem_req, 1);
      chk({tag, " hold addr"}, mem_addr, a);
      chk({tag, " hold be"}, mem_be, be);
      chk({tag, " hold we"}, mem_we, we);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk({tag, " req drop"}, mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic wait_resp(input logic [31:0] rd, input logic err, input string tag);
    int n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, " resp_valid"}, resp_valid, 1);
    chk({tag, " rdata"}, resp_rdata, rd);
    chk({tag, " err"}, resp_err, err);
    @(negedge clk);
    chk({tag, " pulse"}, resp_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst ready", req_ready, 1);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst err", resp_err, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 3'b010, 32'h100, 32'h0, "LW");
    serve(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0, "LW");
    wait_resp(32'hDEADBEEF, 1'b0, "LW");

    issue(1'b0, 3'b000, 32'h103, 32'h0, "LB");
    serve(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80112233, 0, "LB");
    wait_resp(32'hFFFFFF80, 1'b0, "LB");

    issue(1'b0, 3'b100, 32'h103, 32'h0, "LBU");
    serve(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80112233, 0, "LBU");
    wait_resp(32'h00000080, 1'b0, "LBU");

    issue(1'b1, 3'b010, 32'h202, 32'h11223344, "SW");
    serve(32'h200, 4'b1100, 1'b1, 32'h33440000, 32'h0, 0, "SW lo");
    serve(32'h204, 4'b0011, 1'b1, 32'h00001122, 32'h0, 0, "SW hi");
    wait_resp(32'h0, 1'b0, "SW");

    issue(1'b0, 3'b001, 32'h0FF, 32'h0, "LH");
    serve(32'h0FC, 4'b1000, 1'b0, 32'h0, 32'h7F000000, 3, "LH lo");
    serve(32'h100, 4'b0001, 1'b0, 32'h0, 32'h000000AA, 3, "LH hi");
    wait_resp(32'hFFFFAA7F, 1'b0, "LH");

    issue(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0, "LWwrap");
    serve(32'hFFFFFFFC, 4'b1110, 1'b0, 32'h0, 32'hCCBBAA99, 0, "LWwrap lo");
    serve(32'h00000000, 4'b0001, 1'b0, 32'h0, 32'h000000DD, 0, "LWwrap hi");
    wait_resp(32'hDDCCBBAA, 1'b0, "LWwrap");

    issue(1'b1, 3'b001, 32'h3FE, 32'h0000BEEF, "SH");
    serve(32'h3FC, 4'b1100, 1'b1, 32'hBEEF0000, 32'h0, 1, "SH");
    wait_resp(32'h0, 1'b0, "SH");

    issue(1'b0, 3'b011, 32'h100, 32'h0, "F3ill");
    chk("F3ill mem_req", mem_req, 0);
    wait_resp(32'h0, 1'b1, "F3ill");

    issue(1'b1, 3'b100, 32'h100, 32'h0, "SBU");
    chk("SBU mem_req", mem_req, 0);
    wait_resp(32'h0, 1'b1, "SBU");

    chk("NS ready", b_req_ready, 1);
    b_req_we = 1'b0; b_req_funct3 = 3'b010; b_req_addr = 32'h1; b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("NS resp_valid", b_resp_valid, 1);
    chk("NS err", b_resp_err, 1);
    chk("NS mem_req", b_mem_req, 0);
    @(negedge clk);
    chk("NS pulse", b_resp_valid, 0);

    issue(1'b0, 3'b010, 32'h100, 32'h0, "RST");
    chk("RST mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("RST ready", req_ready, 1);
    chk("RST resp_valid", resp_valid, 0);
    chk("RST mem_req", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("RST no resp", resp_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
